// File: rtl/db_pipe_sync_pkg.sv
// Shared helpers for the elastic register pipeline: occupancy update decode.
package db_pipe_sync_pkg;

  typedef enum logic [1:0] {
    OCC_HOLD,
    OCC_INC,
    OCC_DEC,
    OCC_CLEAR
  } occ_op_e;

  // Simultaneous input and output transfers cancel; clear wins over both.
  function automatic occ_op_e occ_op(input logic clear, input logic in_fire, input logic out_fire);
    if (clear) return OCC_CLEAR;
    if (in_fire && !out_fire) return OCC_INC;
    if (out_fire && !in_fire) return OCC_DEC;
    return OCC_HOLD;
  endfunction

endpackage

// File: rtl/db_pipe_stage.sv
// One elastic pipeline register: takes the upstream word whenever it is empty
// or its own word is leaving downstream.
module db_pipe_stage
  import db_pipe_sync_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  assign ready = !valid | dn_ready;

  // Data only moves with a real word so empty stages keep their last contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= RST_VAL;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (ready) begin
        valid <= up_valid;
      end
      if (ready && up_valid && !flush) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/db_pipe_sync.sv
// Parametrised elastic register pipeline with valid/ready handshake,
// synchronous flush and a registered occupancy count.
module db_pipe_sync
  import db_pipe_sync_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  if (WIDTH < 1 || DEPTH < 1) begin : g_bad_param
    $error("db_pipe_sync: WIDTH and DEPTH must both be at least 1");
  end

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_fire;
  logic             out_fire;

  // Each stage keeps its own ready net so the chain has no vector self-dependency.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             dn_ready;
    logic             rdy;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_body
      assign up_valid = v[i-1];
      assign up_data  = d[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_link
      assign dn_ready = g_stage[i+1].rdy;
    end

    db_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (up_valid),
      .up_data  (up_data),
      .dn_ready (dn_ready),
      .valid    (v[i]),
      .data     (d[i]),
      .ready    (rdy)
    );
  end

  assign in_ready  = g_stage[0].rdy & !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    case (occ_op(rst | flush, in_fire, out_fire))
      OCC_CLEAR: occupancy <= '0;
      OCC_INC:   occupancy <= occupancy + OCC_W'(1);
      OCC_DEC:   occupancy <= occupancy - OCC_W'(1);
      default:   occupancy <= occupancy;
    endcase
  end

endmodule

// File: tb/tb_db_pipe_sync.sv
// Self-checking bench for db_pipe_sync: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-of-words reference model.
module tb_db_pipe_sync;

  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 4;
  localparam logic [7:0] RST_VAL = 8'hA5;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] occupancy;

  db_pipe_sync #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A word in flight and the stage it currently sits in (0 = input side).
  typedef struct {
    logic [7:0] data;
    int         pos;
  } entry_t;

  entry_t model_q[$];
  int     checks      = 0;
  int     errors      = 0;
  int     edge_count  = 0;
  int     accept_01   = -1;
  bit     lat_checked = 1'b0;
  bit     data_is_rst = 1'b1;
  bit     seen_34     = 1'b0;
  bit     seen_35     = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Any empty stage, or a consumer taking the last word, makes room at the input.
  function automatic bit model_in_ready(input bit fl, input bit ordy);
    return !fl && (model_q.size() < DEPTH || ordy);
  endfunction

  function automatic bit model_out_valid();
    return model_q.size() > 0 && model_q[0].pos == DEPTH - 1;
  endfunction

  task automatic applyStimulus(input bit r, input bit fl, input bit iv, input logic [7:0] id, input bit ordy);
    bit exp_ir;
    bit exp_ov;
    bit in_fire;
    bit out_fire;
    int ahead;
    @(negedge clk);
    rst       = r;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    exp_ir = model_in_ready(fl, ordy);
    exp_ov = model_out_valid();
    checkOutput("in_ready", in_ready, exp_ir);
    checkOutput("out_valid", out_valid, exp_ov);
    checkOutput("occupancy", occupancy, model_q.size());
    if (exp_ov) checkOutput("out_data", out_data, model_q[0].data);
    else if (data_is_rst) checkOutput("out_data_rst", out_data, RST_VAL);
    if (exp_ov && model_q[0].data == 8'h01 && accept_01 >= 0 && !lat_checked) begin
      checkOutput("latency_01", edge_count - accept_01, DEPTH - 1);
      lat_checked = 1'b1;
    end
    if (out_valid === 1'b1 && ordy && out_data === 8'h34) seen_34 = 1'b1;
    if (out_valid === 1'b1 && ordy && out_data === 8'h35) seen_35 = 1'b1;

    @(posedge clk);
    edge_count++;
    if (r) begin
      model_q.delete();
      data_is_rst = 1'b1;
    end else begin
      in_fire  = iv && exp_ir;
      out_fire = exp_ov && ordy;
      if (out_fire) void'(model_q.pop_front());
      if (fl) begin
        model_q.delete();
      end else begin
        ahead = DEPTH;
        foreach (model_q[k]) begin
          if (model_q[k].pos + 1 < ahead) begin
            model_q[k].pos++;
            if (model_q[k].pos == DEPTH - 1) data_is_rst = 1'b0;
          end
          ahead = model_q[k].pos;
        end
        if (in_fire) begin
          model_q.push_back('{data: id, pos: 0});
          if (DEPTH == 1) data_is_rst = 1'b0;
          if (id == 8'h01 && accept_01 < 0) accept_01 = edge_count;
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held with a live producer: nothing may get in.
    repeat (2) applyStimulus(1, 0, 1, 8'h3C, 0);
    repeat (6) applyStimulus(0, 0, 0, 8'h00, 1);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 1, 8'(i), 1);
    repeat (6) applyStimulus(0, 0, 0, 8'h00, 1);

    // Backpressure fill, rejected extra word, then drain.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 8'(8'h10 + i), 0);
    repeat (2) applyStimulus(0, 0, 1, 8'h14, 0);
    repeat (6) applyStimulus(0, 0, 0, 8'h00, 1);

    // Bubble collapse under a stalled consumer.
    applyStimulus(0, 0, 1, 8'h20, 0);
    repeat (2) applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 8'h21, 0);
    repeat (3) applyStimulus(0, 0, 0, 8'h00, 0);
    repeat (4) applyStimulus(0, 0, 0, 8'h00, 1);

    // Flush drops both the stored words and the concurrent input.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 8'(8'h30 + i), 0);
    applyStimulus(0, 1, 1, 8'h34, 0);
    applyStimulus(0, 0, 1, 8'h35, 1);
    repeat (6) applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("flushed_word_emitted", seen_34, 1'b0);
    checkOutput("post_flush_word_emitted", seen_35, 1'b1);
    checkOutput("latency_observed", lat_checked, 1'b1);

    // Reset while full and stalled.
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 8'(8'h40 + i), 0);
    applyStimulus(1, 0, 0, 8'h00, 0);
    repeat (6) applyStimulus(0, 0, 0, 8'h00, 1);

    // Random traffic with occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/db_pipe_sync.md
Name: db_pipe_sync

Overview:
- Parametrised elastic register pipeline. It generalises the team's 8-bit synchronous-reset D register to WIDTH bits and DEPTH stages.
- Each stage is one register. Every stage has a valid/ready handshake and collapses bubbles independently.
- Adds a synchronous flush and an occupancy count.
- Sits between producer and consumer datapaths that need fixed retiming plus backpressure absorption.

Parameters:
- WIDTH, 8: data width in bits, >= 1.
- DEPTH, 4: number of register stages, >= 1. DEPTH = 0 is an elaboration error.
- RST_VAL, 0 (WIDTH bits): value loaded into every data register on reset.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of all valid bits.
- in_valid  in  1  producer has data on in_data.
- in_ready  out  1  pipeline accepts in_data this cycle.
- in_data  in  WIDTH  input word.
- out_valid  out  1  last stage holds valid data.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  WIDTH  output word; equals last-stage register.
- occupancy  out  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- Reset: one clock and reset, synchronous active-high as decided. rst is sampled on the rising edge of clk.
  - rst clears all stage valid bits to 0.
  - rst loads RST_VAL into all data registers.
  - Therefore out_valid = 0, out_data = RST_VAL and occupancy = 0 after the edge.
- rst priority: rst dominates flush and all handshakes. A reset mid-transfer discards every in-flight word.
- Stage i (0 = input side, DEPTH-1 = output side) holds v[i] and d[i].
- Stage ready: r[i] = !v[i] | r[i+1], with r[DEPTH] = out_ready. The ready chain is combinational.
- in_ready = r[0] & !flush.
- Stage 0 load: stage 0 loads when in_valid & in_ready.
  - Then v[0] <= 1 and d[0] <= in_data.
  - Otherwise, if r[0], v[0] <= 0 (its word moved on or it was already empty).
- Stage i > 0: loads d[i-1] and v[i-1] whenever r[i] = 1. When r[i] = 0 it holds its contents.
- Data registers load only on a valid transfer. Empty-stage data is don't-care but must not be X after reset.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N+DEPTH-1 (DEPTH register stages), provided there is no backpressure.
- Throughput: 1 word/cycle while out_ready = 1, including when the pipe is full.
- Full pipe (all v = 1) with out_ready = 0: in_ready = 0, all stages hold, out_data is stable.
- Bubble collapse: with out_ready = 0, empty stages downstream still advance. Words pack toward the output until the pipe is full.
- flush (without rst):
  - Clears all v[i] at the edge.
  - in_ready is low in a flush cycle, so input is dropped.
  - Data registers are not cleared.
  - flush concurrent with out_valid & out_ready: the output transfer in that cycle completes (consumer sees it), then the pipe is empty.
- occupancy: registered. It equals the popcount of v after each edge.
  - Change per cycle: +1 on input transfer only, -1 on output transfer only, 0 on both or neither.
  - Goes to 0 on flush/rst.
  - Never exceeds DEPTH.
- No ordering change: words exit in acceptance order with no duplication or loss, except by flush/rst.

Decomposition:
- No shared package types are required.
- OCC_W = $clog2(DEPTH+1) is a local constant.
- One sub-module is natural: db_pipe_stage (WIDTH, RST_VAL; ports clk, rst, flush, up_valid, up_data, dn_ready, valid, data, ready).
- db_pipe_sync instantiates DEPTH db_pipe_stage instances in a generate loop.
- The occupancy counter lives at the top level.

Test Plan (WIDTH=8, DEPTH=4, RST_VAL=8'hA5):
- Reset: assert rst 2 cycles with in_valid = 1 and in_data = 8'h3C -> out_valid = 0, out_data = 8'hA5, occupancy = 0, nothing emitted after release.
- Streaming: out_ready = 1, send 8'h01..8'h08 on consecutive cycles -> 8'h01 appears 3 cycles after its acceptance edge. One word per cycle in order. occupancy saturates at 4 (DEPTH) during streaming.
- Backpressure:
  - out_ready = 0, send 8'h10..8'h13 -> in_ready falls after the 4th accept, occupancy = 4, out_data holds 8'h10.
  - Raise out_ready -> 8'h10..8'h13 drain in order.
- Bubble collapse: send 8'h20, idle 2 cycles, send 8'h21 with out_ready = 0 -> both words pack into stages 3 and 2, occupancy = 2, in_ready stays 1.
- Flush: fill with 8'h30..8'h33, pulse flush with in_valid = 1 and in_data = 8'h34 -> occupancy = 0 next cycle, 8'h34 is never emitted, and a new word 8'h35 is emitted.
- rst during backpressure: pipe full, rst for 1 cycle -> all valid cleared, out_data = 8'hA5, no stale words emitted afterwards.
